// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle; define SEQ_DIVIDER_DBZ_EN for early divide-by-zero exit with a dbz flag
module seq_divider #(
  parameter int N = 8,
  parameter int NUM_OPS = 6,
  localparam int DW = N + $clog2(NUM_OPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [N-1:0]  remainder
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic          dbz
`endif
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0] pr_q, pr_d, dvs_q, dvs_d, rem_q, rem_d, diff, pr_nx;
  logic [DW-1:0] sh_q, sh_d, quo_q, quo_d, q_nx;
  logic [N:0] pr_sh;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, dbz_q, dbz_d, borrow, take;
  // partial remainder stays below the divisor, so only a set top bit of the shifted value forces a subtract
  assign pr_sh = {pr_q, sh_q[DW-1]};
  assign {borrow, diff} = {1'b0, pr_sh[N-1:0]} - {1'b0, dvs_q};
  assign take = pr_sh[N] | ~borrow;
  assign pr_nx = take ? diff : pr_sh[N-1:0];
  assign q_nx = {sh_q[DW-2:0], take};
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pr_d = pr_q;
    sh_d = sh_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        sh_d = dividend;
        dvs_d = divisor;
        pr_d = '0;
        count_d = '0;
        dbz_d = 1'b0;
      end
      BUSY: begin
`ifdef SEQ_DIVIDER_DBZ_EN
        if (dvs_q == '0) begin
          state_d = DONE;
          quo_d = '1;
          rem_d = sh_q[N-1:0];
          dbz_d = 1'b1;
        end else begin
`else
        begin
`endif
          pr_d = pr_nx;
          sh_d = q_nx;
          count_d = count_q + 1'b1;
          if (count_q == CW'(DW - 1)) begin
            state_d = DONE;
            quo_d = q_nx;
            rem_d = pr_nx;
          end
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pr_q <= '0;
      sh_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pr_q <= pr_d;
      sh_q <= sh_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient = quo_q;
  assign remainder = rem_q;
`ifdef SEQ_DIVIDER_DBZ_EN
  assign dbz = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_q;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; each task drives one scenario and checks inline
module tb_seq_divider;
  localparam int N = 8;
  localparam int NUM_OPS = 6;
  localparam int DW = N + $clog2(NUM_OPS);
  typedef struct {
    logic [DW-1:0] q;
    logic [N-1:0] r;
    int lat;
    logic z;
  } exp_t;
  exp_t sb[$];
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, dbz_o;
  logic [DW-1:0] dividend = '0, quotient;
  logic [N-1:0] divisor = '0, remainder;
  int checks = 0, failures = 0, cyc = 0;
  seq_divider #(.N(N), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
`ifdef SEQ_DIVIDER_DBZ_EN
    , .dbz(dbz_o)
`endif
  );
`ifndef SEQ_DIVIDER_DBZ_EN
  assign dbz_o = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [N-1:0] b, output int acc);
    exp_t e;
    in_valid = 1;
    dividend = a;
    divisor = b;
    for (int i = 0; i < 60 && !in_ready; i++) tick();
    tick();
    in_valid = 0;
    acc = cyc;
    e.q = (b == 0) ? {DW{1'b1}} : a / DW'(b);
    e.r = (b == 0) ? a[N-1:0] : N'(a % DW'(b));
`ifdef SEQ_DIVIDER_DBZ_EN
    e.lat = (b == 0) ? 1 : DW;
    e.z = (b == 0);
`else
    e.lat = DW;
    e.z = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic collect(output logic [DW-1:0] q, output logic [N-1:0] r, output int lat, output bit rs, output logic z);
    lat = 0;
    rs = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rs = 1;
      tick();
      lat++;
    end
    q = quotient;
    r = remainder;
    z = dbz_o;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs; exp_t e;
    send(100, 6, acc);
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    checks++; if (q !== e.q) begin failures++; $display("FAIL basic_q got=%0d exp=%0d", q, e.q); end
    checks++; if (r !== e.r) begin failures++; $display("FAIL basic_r got=%0d exp=%0d", r, e.r); end
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL basic_in_ready_busy got=%b exp=0", rs); end
    tick();
  endtask

  task automatic test_edges();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs; exp_t e;
    logic [DW-1:0] as [3] = '{2047, 5, 0};
    logic [N-1:0] bs [3] = '{1, 255, 7};
    for (int i = 0; i < 3; i++) begin
      send(as[i], bs[i], acc);
      collect(q, r, lat, rs, z);
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) begin failures++; $display("FAIL edge%0d got=%0d/%0d exp=%0d/%0d", i, q, r, e.q, e.r); end
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL edge%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      tick();
    end
  endtask

  task automatic test_dbz();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs; exp_t e;
    send(1234, 0, acc);
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    checks++; if (q !== 11'd2047) begin failures++; $display("FAIL dbz_q got=%0d exp=2047", q); end
    checks++; if (r !== 8'd210) begin failures++; $display("FAIL dbz_r got=%0d exp=210", r); end
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL dbz_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (z !== e.z) begin failures++; $display("FAIL dbz_flag got=%b exp=%b", z, e.z); end
    tick();
    send(10, 3, acc);
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    checks++; if (z !== 1'b0 || q !== e.q || r !== e.r) begin failures++; $display("FAIL dbz_clear got=%b %0d/%0d exp=0 %0d/%0d", z, q, r, e.q, e.r); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs; exp_t e;
    out_ready = 0;
    send(77, 7, acc);
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || quotient !== e.q || remainder !== e.r) begin failures++; $display("FAIL bp_hold%0d got=%b %0d/%0d exp=1 %0d/%0d", i, out_valid, quotient, remainder, e.q, e.r); end
      tick();
    end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready); end
  endtask

  task automatic test_reset_midop();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs, seen; exp_t e;
    send(200, 3, acc);
    void'(sb.pop_front());
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0) begin failures++; $display("FAIL rst_mid got=valid%b ready%b %0d/%0d exp=valid0 ready1 0/0", out_valid, in_ready, quotient, remainder); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid got=%b exp=0", seen); end
    send(200, 3, acc);
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    checks++; if (q !== e.q || r !== e.r) begin failures++; $display("FAIL rst_mid_redo got=%0d/%0d exp=%0d/%0d", q, r, e.q, e.r); end
    tick();
  endtask

  task automatic test_busy_input();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc; bit rs; exp_t e;
    send(150, 7, acc);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      dividend = 99;
      divisor = 9;
      tick();
    end
    in_valid = 0;
    collect(q, r, lat, rs, z);
    e = sb.pop_front();
    checks++; if (q !== e.q || r !== e.r) begin failures++; $display("FAIL busy_input got=%0d/%0d exp=%0d/%0d", q, r, e.q, e.r); end
    checks++; if (lat + 6 !== e.lat) begin failures++; $display("FAIL busy_input_latency got=%0d exp=%0d", lat + 6, e.lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q; logic [N-1:0] r; logic z; int lat, acc, prev; bit rs; exp_t e;
    logic [DW-1:0] as [3] = '{1500, 999, 64};
    logic [N-1:0] bs [3] = '{13, 200, 8};
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(as[i], bs[i], acc);
      if (i > 0) begin
        checks++; if (acc - prev !== DW + 2) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, acc - prev, DW + 2); end
      end
      prev = acc;
      collect(q, r, lat, rs, z);
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) begin failures++; $display("FAIL b2b%0d got=%0d/%0d exp=%0d/%0d", i, q, r, e.q, e.r); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_dbz();
    test_backpressure();
    test_reset_midop();
    test_busy_input();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider. Uses one subtract/compare per cycle over the operand widths of the multi-operand adder path.
- Typical use: divide an accumulated sum (N+$clog2(NUM_OPS) bits) by an N-bit divisor, e.g. sum/NUM_OPS for a mean.
- Valid/ready handshake on input and output, so it sits directly downstream of the adder tree.
- Sequential counterpart to the combinational summation path.

Parameters:
- N, 8, divisor width and remainder width.
- NUM_OPS, 6, operand count of the upstream sum. Sets dividend width DW = N+$clog2(NUM_OPS).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  high only in IDLE.
- dividend  input  DW  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result available (DONE state).
- out_ready  input  1  consumer accepts result.
- quotient  output  DW  unsigned quotient.
- remainder  output  N  unsigned remainder.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch dividend into the quotient/shift register, latch divisor, clear the (N+1)-bit partial remainder, set count=0, go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge: shift {partial remainder, shift register} left by 1.
  - trial = partial remainder − {1'b0, divisor}, using N+2-bit arithmetic.
  - If trial is non-negative: partial remainder=trial, shifted-in quotient LSB=1. Otherwise restore, LSB=0.
  - count increments each edge. After the DW-th iteration edge, go to DONE.
- DONE:
  - out_valid=1.
  - quotient and remainder (low N bits of the partial remainder) are stable.
  - While out_ready=0: hold all outputs unchanged, indefinitely.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid=0.
  - quotient/remainder outputs keep their last values until the next acceptance.
- Latency: out_valid rises exactly DW edges after the acceptance edge (11 cycles at defaults).
- Throughput: minimum DW+2 cycles per operation. IDLE is always visited, so there is one bubble between the DONE handshake and the next acceptance.
- Divide by zero: no special-casing; the natural restoring result is required. quotient = all ones (2^DW−1), remainder = dividend[N-1:0]. Latency is the same.
- Edge values:
  - divisor > dividend gives quotient=0, remainder=dividend.
  - dividend=0 gives 0/0 (quotient 0, remainder 0).
- Reset mid-operation (BUSY or DONE): next edge goes to IDLE with reset values. The in-flight result is discarded and no out_valid pulse is produced.
- rst has priority over any simultaneous handshake.

Optional Feature:
- Macro: SEQ_DIVIDER_DBZ_EN.
- Defined:
  - Adds output port dbz (1 bit, reset 0).
  - On acceptance with divisor==0, go directly to DONE on the next edge (latency 1).
  - quotient = 2^DW−1, remainder = dividend[N-1:0], dbz=1.
  - dbz is valid with out_valid and clears when the next operation is accepted.
- Undefined: no dbz port; divide by zero takes the full DW-cycle path with the same result values.

Test Plan:
- Default params: dividend=100, divisor=6, out_ready=1 -> out_valid exactly 11 edges after acceptance, quotient=16, remainder=4, in_ready low throughout BUSY.
- dividend=2047, divisor=1 -> quotient=2047, remainder=0. Then dividend=5, divisor=255 -> quotient=0, remainder=5.
- dividend=1234, divisor=0:
  - Macro undefined -> quotient=2047, remainder=210 after 11 cycles.
  - Macro defined -> same values, dbz=1, latency 1.
- Backpressure: dividend=77, divisor=7, out_ready held 0 for 5 cycles after out_valid -> quotient=11, remainder=0 stable each cycle. Release -> out_valid drops next edge, in_ready=1.
- Reset mid-op: accept 200/3, assert rst at 4th BUSY cycle -> next edge IDLE, out_valid=0, quotient=remainder=0, no later out_valid. Subsequent 200/3 -> quotient=66, remainder=2.
- Input during BUSY: toggle in_valid with new operands while BUSY -> ignored, original result returned. Back-to-back ops show one idle bubble.
